// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter.
package rf_arb_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned XLEN_DEFAULT = 32;

    // IDLE: no MDU result queued; PEND: results queued, writeback wins;
    // FORCE: oldest MDU result takes the write port and writeback stalls.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Two-entry FIFO holding MDU results waiting for the register-file port.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int unsigned WIDTH = REG_ADDR_W + XLEN_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [1:0]       count_next_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] slot_q [2];
    logic [WIDTH-1:0] slot_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    // Next-state of storage, pointers and occupancy; push and pop may coincide.
    always_comb begin
        do_push  = push_i && (count_q != 2'd2);
        do_pop   = pop_i  && (count_q != 2'd0);
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            slot_d[wr_ptr_q] = push_data_i;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset discards any queued results.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            slot_q   <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign head_o       = slot_q[rd_ptr_q];

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback and a
// queued multi-cycle MDU, forcing the MDU through after bounded starvation.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned XLEN         = XLEN_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]       wb_data_i,
    input  logic                  mdu_valid_i,
    input  logic [REG_ADDR_W-1:0] mdu_rd_i,
    input  logic [XLEN-1:0]       mdu_data_i,
    output logic                  mdu_ready_o,
    output logic                  stall_o,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]       rf_wdata_o
);

    arb_state_t            state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

    logic                  grant_wb, grant_mdu;
    logic                  push;
    logic [1:0]            fifo_count, fifo_count_next;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;

    assign mdu_ready_o = ~reset_i & (fifo_count != 2'd2);
    assign push        = mdu_valid_i & mdu_ready_o;

    rf_arb_fifo #(
        .WIDTH (REG_ADDR_W + XLEN)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_i       (push),
        .push_data_i  ({mdu_rd_i, mdu_data_i}),
        .pop_i        (grant_mdu),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next),
        .head_o       ({head_rd, head_data})
    );

    // State, starvation counter and write-port registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Next state: IDLE/PEND follow the post-update occupancy; FORCE lasts one cycle.
    always_comb begin
        if (grant_mdu) begin
            starve_d = '0;
        end else if ((state_q == PEND) && grant_wb && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end

        state_d = state_q;
        unique case (state_q)
            PEND: begin
                if (fifo_count_next == 2'd0) begin
                    state_d = IDLE;
                end else if (starve_d >= 4'(STARVE_LIMIT)) begin
                    state_d = FORCE;
                end else begin
                    state_d = PEND;
                end
            end
            IDLE, FORCE: state_d = (fifo_count_next == 2'd0) ? IDLE : PEND;
            default:     state_d = IDLE;
        endcase
    end

    // Grant decode from the state register; stall depends on state alone.
    always_comb begin
        grant_wb  = 1'b0;
        grant_mdu = 1'b0;
        stall_o   = 1'b0;
        unique case (state_q)
            IDLE: grant_wb = wb_valid_i;
            PEND: begin
                grant_wb  = wb_valid_i;
                grant_mdu = ~wb_valid_i;
            end
            FORCE: begin
                grant_mdu = 1'b1;
                stall_o   = 1'b1;
            end
            default: ;
        endcase
    end

    // Write-port next values; x0 grants update address/data but never write.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_mdu) begin
            rf_we_d    = (head_rd != '0);
            rf_waddr_d = head_rd;
            rf_wdata_d = head_data;
        end else if (grant_wb) begin
            rf_we_d    = (wb_rd_i != '0);
            rf_waddr_d = wb_rd_i;
            rf_wdata_d = wb_data_i;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, reset
// corner sequence, then randomized traffic against a queue-based model.
module tb_rf_write_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        mdu_valid_i = 1'b0;
    logic [4:0]  mdu_rd_i = '0;
    logic [31:0] mdu_data_i = '0;
    logic        mdu_ready_o, stall_o, rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    int n_cmp = 0;
    int n_bad = 0;

    rf_write_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .wb_valid_i  (wb_valid_i),
        .wb_rd_i     (wb_rd_i),
        .wb_data_i   (wb_data_i),
        .mdu_valid_i (mdu_valid_i),
        .mdu_rd_i    (mdu_rd_i),
        .mdu_data_i  (mdu_data_i),
        .mdu_ready_o (mdu_ready_o),
        .stall_o     (stall_o),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wbv;  logic [4:0] wrd; logic [31:0] wdat;
        logic        mv;   logic [4:0] mrd; logic [31:0] mdat;
        logic        we;   logic [4:0] addr; logic [31:0] data;
        logic        rdy;  logic st;
    } vec_t;

    typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

    // Reference model: queue of pending results, count of lost cycles.
    ent_t        mq[$];
    int          lost;
    bit          force_pend;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wbv, input logic [4:0] wrd, input logic [31:0] wdat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
        wb_valid_i = wbv; wb_rd_i = wrd; wb_data_i = wdat;
        mdu_valid_i = mv; mdu_rd_i = mrd; mdu_data_i = mdat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic rdy, input logic st);
        check({tag, " we"},    32'(rf_we_o),     32'(we));
        check({tag, " waddr"}, 32'(rf_waddr_o),  32'(addr));
        check({tag, " wdata"}, rf_wdata_o,       data);
        check({tag, " ready"}, 32'(mdu_ready_o), 32'(rdy));
        check({tag, " stall"}, 32'(stall_o),     32'(st));
    endtask

    // One clock edge of the model: the forced cycle or an idle writeback
    // hands the port to the oldest result; otherwise writeback wins and the
    // queued result loses a cycle.
    task automatic model_edge(input logic wbv, input logic [4:0] wrd, input logic [31:0] wdat,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
        bit   had, accept, take_mdu;
        ent_t head;
        had      = mq.size() > 0;
        accept   = mv && (mq.size() < 2);
        take_mdu = force_pend || (had && !wbv);
        m_we     = 1'b0;
        if (take_mdu) begin
            head   = mq.pop_front();
            m_we   = (head.rd != 5'd0);
            m_addr = head.rd;
            m_data = head.data;
            lost   = 0;
        end else if (wbv) begin
            m_we   = (wrd != 5'd0);
            m_addr = wrd;
            m_data = wdat;
            if (had) lost++;
        end
        force_pend = had && !take_mdu && (lost >= LIMIT);
        if (accept) mq.push_back(ent_t'{mrd, mdat});
    endtask

    vec_t tbl[$];

    initial begin
        // wbv wrd wdat | mv mrd mdat | we addr data rdy st
        tbl.push_back(vec_t'{1, 5,  32'hDEADBEEF, 0, 0,  0,            1, 5,  32'hDEADBEEF, 1, 0});
        tbl.push_back(vec_t'{0, 0,  0,            0, 0,  0,            0, 5,  32'hDEADBEEF, 1, 0});
        tbl.push_back(vec_t'{0, 0,  0,            1, 7,  32'h12345678, 0, 5,  32'hDEADBEEF, 1, 0});
        tbl.push_back(vec_t'{0, 0,  0,            0, 0,  0,            1, 7,  32'h12345678, 1, 0});
        tbl.push_back(vec_t'{0, 0,  0,            0, 0,  0,            0, 7,  32'h12345678, 1, 0});
        tbl.push_back(vec_t'{1, 0,  32'hFFFFFFFF, 0, 0,  0,            0, 0,  32'hFFFFFFFF, 1, 0});
        tbl.push_back(vec_t'{0, 0,  0,            1, 9,  32'hA5A5A5A5, 0, 0,  32'hFFFFFFFF, 1, 0});
        tbl.push_back(vec_t'{1, 2,  32'h102,      0, 0,  0,            1, 2,  32'h102,      1, 0});
        tbl.push_back(vec_t'{1, 3,  32'h103,      0, 0,  0,            1, 3,  32'h103,      1, 0});
        tbl.push_back(vec_t'{1, 4,  32'h104,      0, 0,  0,            1, 4,  32'h104,      1, 0});
        tbl.push_back(vec_t'{1, 5,  32'h105,      0, 0,  0,            1, 5,  32'h105,      1, 1});
        tbl.push_back(vec_t'{1, 5,  32'h105,      0, 0,  0,            1, 9,  32'hA5A5A5A5, 1, 0});
        tbl.push_back(vec_t'{1, 5,  32'h105,      0, 0,  0,            1, 5,  32'h105,      1, 0});
        tbl.push_back(vec_t'{0, 0,  0,            0, 0,  0,            0, 5,  32'h105,      1, 0});
        tbl.push_back(vec_t'{1, 10, 32'h10A,      1, 11, 32'hB1,       1, 10, 32'h10A,      1, 0});
        tbl.push_back(vec_t'{1, 12, 32'h10C,      1, 13, 32'hB2,       1, 12, 32'h10C,      0, 0});
        tbl.push_back(vec_t'{1, 14, 32'h10E,      1, 15, 32'hB3,       1, 14, 32'h10E,      0, 0});
        tbl.push_back(vec_t'{1, 16, 32'h110,      1, 15, 32'hB3,       1, 16, 32'h110,      0, 0});
        tbl.push_back(vec_t'{1, 17, 32'h111,      1, 15, 32'hB3,       1, 17, 32'h111,      0, 1});
        tbl.push_back(vec_t'{1, 17, 32'h111,      1, 15, 32'hB3,       1, 11, 32'hB1,       1, 0});
        tbl.push_back(vec_t'{1, 17, 32'h111,      1, 15, 32'hB3,       1, 17, 32'h111,      0, 0});
        tbl.push_back(vec_t'{0, 0,  0,            0, 0,  0,            1, 13, 32'hB2,       1, 0});
        tbl.push_back(vec_t'{0, 0,  0,            0, 0,  0,            1, 15, 32'hB3,       1, 0});
        tbl.push_back(vec_t'{0, 0,  0,            0, 0,  0,            0, 15, 32'hB3,       1, 0});

        // Reset values are visible before any clock edge.
        #1 reset_i = 1'b1;
        #2 check_all("reset", 0, 0, 0, 0, 0);
        step();
        @(negedge clk) reset_i = 1'b0;
        step();
        check_all("post_reset", 0, 0, 0, 1, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].wbv, tbl[i].wrd, tbl[i].wdat, tbl[i].mv, tbl[i].mrd, tbl[i].mdat);
            step();
            check_all($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].data,
                      tbl[i].rdy, tbl[i].st);
        end

        // Reach FORCE with two results queued, then reset mid-cycle.
        drive(1, 1, 32'h1, 1, 20, 32'hC0); step();
        drive(1, 2, 32'h2, 1, 21, 32'hC1); step();
        for (int k = 3; k <= 5; k++) begin
            drive(1, 5'(k), 32'(k), 0, 0, 0);
            step();
        end
        check("force stall", 32'(stall_o), 32'd1);
        check("force ready", 32'(mdu_ready_o), 32'd0);
        #2;
        drive(0, 0, 0, 0, 0, 0);
        reset_i = 1'b1;
        #1 check_all("mid_reset", 0, 0, 0, 0, 0);
        step();
        @(negedge clk) reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_all($sformatf("after_reset%0d", k), 0, 0, 0, 1, 0);
        end

        // Randomized traffic against the model, starting from reset.
        mq.delete();
        lost = 0; force_pend = 0;
        m_we = 0; m_addr = '0; m_data = '0;
        @(negedge clk) reset_i = 1'b1;
        @(negedge clk) reset_i = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic        wbv, mv;
            logic [4:0]  wrd, mrd;
            logic [31:0] wdat, mdat;
            wbv  = ($urandom_range(0, 9) < 6);
            wrd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wdat = $urandom;
            mv   = ($urandom_range(0, 1) == 1);
            mrd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mdat = $urandom;
            drive(wbv, wrd, wdat, mv, mrd, mdat);
            model_edge(wbv, wrd, wdat, mv, mrd, mdat);
            step();
            check_all($sformatf("rand%0d", c), m_we, m_addr, m_data,
                      (mq.size() < 2), force_pend);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
